// File: rtl/led_ctrl_pkg.sv
// Shared control definitions for the LED round sequencer family.
// Provides the sequencer state type, the round-constant seed, round counts
// for LED-64/LED-128 and the round-constant LFSR update rule.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  localparam logic [5:0] RC_INIT = 6'h01;

  localparam int unsigned LED128_ROUNDS   = 48;
  localparam int unsigned LED64_ROUNDS    = 32;
  localparam int unsigned ROUNDS_PER_STEP = 4;

  // 6-bit XNOR LFSR step: shift left, feed back rc[5] ~^ rc[4].
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ~^ rc[4]};
  endfunction

endpackage

// File: rtl/led_rc_lfsr.sv
// Round-constant generator for the LED round datapath.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset, loads RC_INIT
//   clr - reload RC_INIT on the next edge (takes priority over en)
//   en  - advance the LFSR by one round
//   rc  - current 6-bit round constant
module led_rc_lfsr
  import led_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] rc
);

  logic [5:0] rc_d, rc_q;

  always_comb begin
    rc_d = rc_q;
    if (clr) begin
      rc_d = RC_INIT;
    end else if (en) begin
      rc_d = rc_next(rc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= RC_INIT;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc = rc_q;

endmodule

// File: rtl/led_masked_round_sequencer.sv
// Start/done sequencer for the masked LED-128 round datapath.
// Accepts one request, then steps the S-box pipeline one stage per accepted
// PRNG transfer, producing round enable, round constant and key-addition
// controls. Stalls while the PRNG has no fresh mask bits.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - request, sampled only when idle
//   rand_valid          - PRNG has fresh mask bits for the current stage
//   rand_ready          - sequencer consumes mask bits (high throughout RUN)
//   round_en            - datapath advance, one per accepted stage
//   rc                  - round constant of the current round
//   add_key, sel_key    - add a key half this cycle; 0 = K1, 1 = K2
//   busy                - high from LOAD through DONE
//   done                - one-cycle pulse, ciphertext valid
module led_masked_round_sequencer #(
  parameter int unsigned SBOX_STAGES     = 3,
  parameter int unsigned ROUNDS          = led_ctrl_pkg::LED128_ROUNDS,
  parameter int unsigned ROUNDS_PER_STEP = led_ctrl_pkg::ROUNDS_PER_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rand_valid,
  output logic       rand_ready,
  output logic       round_en,
  output logic [5:0] rc,
  output logic       add_key,
  output logic       sel_key,
  output logic       busy,
  output logic       done
);

  import led_ctrl_pkg::*;

  localparam int unsigned StageW = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
  localparam int unsigned RoundW = $clog2(ROUNDS + 1);
  localparam int unsigned StepW  = $clog2(ROUNDS / ROUNDS_PER_STEP + 1);

  localparam logic [StageW-1:0] StageLast = StageW'(SBOX_STAGES - 1);
  localparam logic [RoundW-1:0] RoundLast = RoundW'(ROUNDS - 1);

  if (ROUNDS % ROUNDS_PER_STEP != 0) begin : g_bad_rounds
    $error("ROUNDS must be a multiple of ROUNDS_PER_STEP");
  end

  state_e              state_d, state_q;
  logic [StageW-1:0]   stage_d, stage_q;
  logic [RoundW-1:0]   round_d, round_q;
  logic [StepW-1:0]    step_d, step_q;
  logic [RoundW-1:0]   round_inc;
  logic                step_hit;
  logic                rc_en;
  logic                rc_clr;

  assign round_inc = round_q + RoundW'(1);
  assign step_hit  = (32'(round_inc) % ROUNDS_PER_STEP) == 32'd0;

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    round_d    = round_q;
    step_d     = step_q;
    rand_ready = 1'b0;
    round_en   = 1'b0;
    add_key    = 1'b0;
    sel_key    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    rc_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        // Initial whitening with K1.
        busy    = 1'b1;
        add_key = 1'b1;
        stage_d = '0;
        round_d = '0;
        step_d  = '0;
        state_d = StRun;
      end
      StRun: begin
        busy       = 1'b1;
        rand_ready = 1'b1;
        if (rand_valid) begin
          round_en = 1'b1;
          if (stage_q == StageLast) begin
            stage_d = '0;
            round_d = round_inc;
            rc_en   = 1'b1;
            if (step_hit) begin
              step_d  = step_q + StepW'(1);
              add_key = 1'b1;
              // (step+1) & 1: odd steps use K2.
              sel_key = ~step_q[0];
            end
            if (round_q == RoundLast) state_d = StDone;
          end else begin
            stage_d = stage_q + StageW'(1);
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // Hold the seed outside RUN so LOAD and the first round see RC_INIT even
  // after a completed run.
  assign rc_clr = (state_q != StRun);

  led_rc_lfsr u_rc_lfsr (
    .clk (clk),
    .rst (rst),
    .clr (rc_clr),
    .en  (rc_en),
    .rc  (rc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_led_masked_round_sequencer.sv
module tb_led_masked_round_sequencer;

  localparam int Rounds    = 48;
  localparam int Stages    = 3;
  localparam int PerStep   = 4;
  localparam int Transfers = Rounds * Stages;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rand_valid;
  logic       rand_ready;
  logic       round_en;
  logic [5:0] rc;
  logic       add_key;
  logic       sel_key;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  led_masked_round_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .round_en   (round_en),
    .rc         (rc),
    .add_key    (add_key),
    .sel_key    (sel_key),
    .busy       (busy),
    .done       (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [5:0] exp_rc[$];
  logic       exp_sel[$];
  int         exp_done[$];
  bit         exp_run = 1'b0;
  bit         mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rand_ready", 32'(rand_ready), 32'(exp_run));
      chk("round_en", 32'(round_en), 32'(exp_run & rand_valid));
      if (round_en === 1'b1) begin
        chk("round_en_expected", 32'(exp_rc.size() > 0), 32'd1);
        if (exp_rc.size() > 0) chk("rc", 32'(rc), 32'(exp_rc.pop_front()));
      end
      if (add_key === 1'b1) begin
        chk("add_key_expected", 32'(exp_sel.size() > 0), 32'd1);
        if (exp_sel.size() > 0) chk("sel_key", 32'(sel_key), 32'(exp_sel.pop_front()));
      end
      if (done === 1'b1) begin
        chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
          chk("done_cycle", cyc, exp_done.pop_front());
          chk("done_rc_left", exp_rc.size(), 32'd0);
          chk("done_key_left", exp_sel.size(), 32'd0);
          chk("done_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  // One encryption. Entered at an IDLE cycle; mode 0 = PRNG always valid,
  // 1 = PRNG starved in cycles 10..14, 2 = random starvation.
  task automatic run_one(input int mode, input bit hold, input int abort_at);
    int m;
    int t;
    bit v;
    bit aborted;
    logic [5:0] r;
    m = cyc;
    start = 1'b1;
    rand_valid = ($urandom_range(1) != 0);
    r = 6'h01;
    for (int i = 0; i < Rounds; i++) begin
      for (int s = 0; s < Stages; s++) exp_rc.push_back(r);
      r = {r[4:0], r[5] ~^ r[4]};
    end
    exp_sel.push_back(1'b0);
    for (int k = 1; k <= Rounds / PerStep; k++) exp_sel.push_back((k % 2) != 0);
    step();  // LOAD
    if (!hold) start = 1'b0;
    rand_valid = ($urandom_range(1) != 0);
    step();  // first RUN cycle
    exp_run = 1'b1;
    t = 0;
    aborted = 1'b0;
    while (t < Transfers && !aborted) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = !((cyc - m) >= 10 && (cyc - m) <= 14);
        default: v = ($urandom_range(3) != 0);
      endcase
      rand_valid = v;
      if (v) t++;
      if (abort_at > 0 && (cyc - m) == abort_at) begin
        rst = 1'b1;
        aborted = 1'b1;
      end else if (t == Transfers) begin
        exp_done.push_back(cyc + 1);
      end
      step();
    end
    exp_run = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      exp_rc.delete();
      exp_sel.delete();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rc", 32'(rc), 32'h01);
      chk("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 4; i++) begin
        rand_valid = ($urandom_range(1) != 0);
        step();
        chk("abort_idle_busy", 32'(busy), 32'd0);
      end
    end else begin
      rand_valid = ($urandom_range(1) != 0);
      step();  // now the IDLE cycle after DONE
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;  // must be ignored under reset
    rand_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("reset_outputs", 32'({busy, done, round_en, add_key, sel_key, rand_ready}), 32'd0);
      chk("reset_rc", 32'(rc), 32'h01);
      rand_valid = ($urandom_range(1) != 0);
      step();
    end
    run_one(0, 1'b0, 0);
    run_one(1, 1'b0, 0);
    run_one(0, 1'b0, 60);
    run_one(0, 1'b0, 0);
    run_one(0, 1'b1, 0);
    run_one(0, 1'b1, 0);
    run_one(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      run_one(2, (i < 3) ? ($urandom_range(1) != 0) : 1'b0, 0);
    end
    for (int i = 0; i < 5; i++) step();
    chk("pending_done", exp_done.size(), 32'd0);
    chk("pending_rc", exp_rc.size(), 32'd0);
    chk("pending_key", exp_sel.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
